// File: rtl/gpio_apb_irq.sv
// APB GPIO controller: per-bit output data/enable, synchronised inputs, and
// edge-detect interrupts with a sticky W1C status and one level irq line.
module gpio_apb_irq #(
  parameter int unsigned GPIO_W      = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_2000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [31:0]       in_paddr,
  input  logic              in_psel,
  input  logic              in_penable,
  input  logic              in_pwrite,
  input  logic [2:0]        in_pprot,
  input  logic [31:0]       in_pwdata,
  input  logic [3:0]        in_pstrb,
  output logic              in_pready,
  output logic [31:0]       in_prdata,
  output logic              in_pslverr,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [GPIO_W-1:0] gpio_oe,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic              irq
);

  localparam logic [9:0] IDX_DATA_OUT   = 10'd0;
  localparam logic [9:0] IDX_DIR        = 10'd1;
  localparam logic [9:0] IDX_DATA_IN    = 10'd2;
  localparam logic [9:0] IDX_IRQ_EN     = 10'd3;
  localparam logic [9:0] IDX_IRQ_RISE   = 10'd4;
  localparam logic [9:0] IDX_IRQ_FALL   = 10'd5;
  localparam logic [9:0] IDX_IRQ_STATUS = 10'd6;

  localparam int unsigned WARM_MAX = SYNC_STAGES + 1;
  localparam int unsigned WARM_W   = $clog2(WARM_MAX + 1);

  logic              pready_q;
  logic [GPIO_W-1:0] out_q,  out_d;
  logic [GPIO_W-1:0] dir_q,  dir_d;
  logic [GPIO_W-1:0] en_q,   en_d;
  logic [GPIO_W-1:0] rise_q, rise_d;
  logic [GPIO_W-1:0] fall_q, fall_d;
  logic [GPIO_W-1:0] stat_q, stat_d;
  logic [GPIO_W-1:0] prev_q;
  logic [GPIO_W-1:0] sync_q [SYNC_STAGES];
  logic [WARM_W-1:0] warm_q, warm_d;

  logic              hit, mapped, err, commit, warm_done;
  logic [9:0]        word_idx;
  logic [31:0]       byte_mask;
  logic [GPIO_W-1:0] wmask, wdata, data_in, evt, w1c, rd_val;
  logic [31:0]       rd_word;
  logic              unused_ok;

  function automatic logic [GPIO_W-1:0] merge(input logic [GPIO_W-1:0] old_v,
                                              input logic [GPIO_W-1:0] new_v,
                                              input logic [GPIO_W-1:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  // Address decode and error classification.
  always_comb begin
    hit      = (in_paddr[31:12] == BASE_ADDR[31:12]);
    word_idx = in_paddr[11:2];
    mapped   = (word_idx <= IDX_IRQ_STATUS);
    err      = !hit || (in_paddr[1:0] != 2'b00) || !mapped ||
               (in_pwrite && (word_idx == IDX_DATA_IN));
  end

  assign byte_mask = {{8{in_pstrb[3]}}, {8{in_pstrb[2]}}, {8{in_pstrb[1]}}, {8{in_pstrb[0]}}};
  assign wmask     = byte_mask[GPIO_W-1:0];
  assign wdata     = in_pwdata[GPIO_W-1:0];
  assign commit    = pready_q && in_psel && in_penable && in_pwrite && !err;
  assign unused_ok = ^{in_pprot, in_pwdata, in_paddr, byte_mask};

  assign data_in   = sync_q[SYNC_STAGES-1];
  assign warm_done = (warm_q == WARM_W'(WARM_MAX));
  assign warm_d    = warm_done ? warm_q : warm_q + 1'b1;
  assign evt       = warm_done ? ((data_in & ~prev_q & rise_q) | (~data_in & prev_q & fall_q))
                               : '0;

  always_comb begin
    rd_val = '0;
    case (word_idx)
      IDX_DATA_OUT:   rd_val = out_q;
      IDX_DIR:        rd_val = dir_q;
      IDX_DATA_IN:    rd_val = data_in;
      IDX_IRQ_EN:     rd_val = en_q;
      IDX_IRQ_RISE:   rd_val = rise_q;
      IDX_IRQ_FALL:   rd_val = fall_q;
      IDX_IRQ_STATUS: rd_val = stat_q;
      default:        rd_val = '0;
    endcase
    rd_word               = '0;
    rd_word[GPIO_W-1:0]   = rd_val;
  end

  // NOTE: every next-state value gets a default before the case, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    en_d   = en_q;
    rise_d = rise_q;
    fall_d = fall_q;
    w1c    = '0;
    if (commit) begin
      case (word_idx)
        IDX_DATA_OUT:   out_d  = merge(out_q,  wdata, wmask);
        IDX_DIR:        dir_d  = merge(dir_q,  wdata, wmask);
        IDX_IRQ_EN:     en_d   = merge(en_q,   wdata, wmask);
        IDX_IRQ_RISE:   rise_d = merge(rise_q, wdata, wmask);
        IDX_IRQ_FALL:   fall_d = merge(fall_q, wdata, wmask);
        IDX_IRQ_STATUS: w1c    = wdata & wmask;
        default:        w1c    = '0;
      endcase
    end
    // A new event outranks a same-cycle clear.
    stat_d = (stat_q & ~w1c) | evt;
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pready_q <= 1'b0;
      out_q    <= '0;
      dir_q    <= '0;
      en_q     <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      stat_q   <= '0;
      prev_q   <= '0;
      warm_q   <= '0;
    end else begin
      pready_q <= in_psel && in_penable && !pready_q;
      out_q    <= out_d;
      dir_q    <= dir_d;
      en_q     <= en_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      stat_q   <= stat_d;
      prev_q   <= data_in;
      warm_q   <= warm_d;
    end
  end

  // NOTE: the synchroniser array is reset like any other register; it is a few
  // flops, not a RAM, and a known start value is what the warm-up relies on.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign in_pready  = pready_q;
  assign in_pslverr = pready_q && err;
  assign in_prdata  = (pready_q && !in_pwrite && !err) ? rd_word : 32'h0;
  assign gpio_out   = out_q;
  assign gpio_oe    = dir_q;
  assign irq        = |(stat_q & en_q);

endmodule
